// File: rtl/wavegen_pkg.sv
// rtl/wavegen_pkg.sv - shared encodings for the waveform sequencer
// Waveform selects, FSM state codes, default period length and triangle fold helper.
package wavegen_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'b00,
    WAVE_SQUARE = 2'b01,
    WAVE_SAW    = 2'b10,
    WAVE_TRI    = 2'b11
  } wave_sel_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int PERIOD_STEPS_DEF = 402;

  // Fold a rising ramp into an up/down ramp of the same period.
  function automatic logic [7:0] tri_fold(input logic [7:0] saw);
    tri_fold = saw[7] ? ~{saw[6:0], 1'b0} : {saw[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/wave_sequencer_rate_divider.sv
// rtl/wave_sequencer_rate_divider.sv - programmable step strobe generator
// Emits one strobe every div_val+1 enabled clocks; clr holds the count at zero.
module rate_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  output logic             strobe
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    strobe    = en && (div_cnt_q == div_val);
    div_cnt_d = div_cnt_q;
    if (clr || strobe) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/wave_sequencer.sv
// rtl/wave_sequencer.sv - run-time controller for the waveform generator
// Paces the oscillator, tracks its phase and shapes/attenuates the output sample.
module wave_sequencer
  import wavegen_pkg::*;
#(
  parameter int DIV_W        = 16,
  parameter int PERIOD_STEPS = PERIOD_STEPS_DEF,
  parameter int STEP_W       = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       wave_sel,
  input  logic [DIV_W-1:0] div_val,
  input  logic [1:0]       amp_shift,
  input  logic [7:0]       osc_data,
  output logic             osc_en,
  output logic             osc_clr,
  output logic [7:0]       wave_out,
  output logic             busy,
  output logic             period_tick
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(PERIOD_STEPS - 1);
  localparam logic [STEP_W-1:0] HALF_STEP = STEP_W'(PERIOD_STEPS / 2);
  // Ramp slope scaled by 2^16 so the sawtooth needs only a constant multiply.
  localparam logic [23:0]       SAW_K     = 24'((1 << 24) / PERIOD_STEPS);

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              stop_pend_q, stop_pend_d;
  logic [1:0]        wave_sel_s_q, wave_sel_s_d;
  logic [DIV_W-1:0]  div_val_s_q, div_val_s_d;
  logic [1:0]        amp_shift_s_q, amp_shift_s_d;
  logic              osc_clr_q, osc_clr_d;
  logic [7:0]        wave_out_q, wave_out_d;

  logic              run;
  logic              boundary;
  logic [STEP_W+23:0] saw_prod;
  logic [STEP_W+7:0]  saw_hi;
  logic [7:0]         saw_v;
  logic [7:0]         v;

  assign run = (state_q == ST_RUN);

  rate_divider #(
    .DIV_W(DIV_W)
  ) u_rate_divider (
    .clk    (clk),
    .rst_n  (rst),
    .clr    (!run),
    .en     (run),
    .div_val(div_val_s_q),
    .strobe (osc_en)
  );

  assign boundary    = osc_en && (step_q == LAST_STEP);
  assign period_tick = boundary;
  assign busy        = (state_q == ST_LOAD) || run;
  assign osc_clr     = osc_clr_q;
  assign wave_out    = wave_out_q;

  always_comb begin
    saw_prod = (STEP_W+24)'(step_q) * (STEP_W+24)'(SAW_K);
    saw_hi   = (STEP_W+8)'(saw_prod >> 16);
    saw_v    = (|saw_hi[STEP_W+7:8]) ? 8'hFF : saw_hi[7:0];
    case (wave_sel_s_q)
      WAVE_SINE:   v = osc_data;
      WAVE_SQUARE: v = (step_q < HALF_STEP) ? 8'hFF : 8'h00;
      WAVE_SAW:    v = saw_v;
      WAVE_TRI:    v = tri_fold(saw_v);
      default:     v = 8'h00;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    stop_pend_d   = stop_pend_q;
    wave_sel_s_d  = wave_sel_s_q;
    div_val_s_d   = div_val_s_q;
    amp_shift_s_d = amp_shift_s_q;
    osc_clr_d     = 1'b0;
    wave_out_d    = run ? (v >> amp_shift_s_q) : 8'h00;

    case (state_q)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          state_d   = ST_LOAD;
          osc_clr_d = 1'b1;
        end
      end
      ST_LOAD: begin
        wave_sel_s_d  = wave_sel;
        div_val_s_d   = div_val;
        amp_shift_s_d = amp_shift;
        step_d        = '0;
        state_d       = ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (osc_en) begin
          step_d = boundary ? '0 : step_q + STEP_W'(1);
        end
        // Settings only change on a period boundary so the output never glitches.
        if (boundary) begin
          wave_sel_s_d  = wave_sel;
          div_val_s_d   = div_val;
          amp_shift_s_d = amp_shift;
          if (stop_pend_q || stop) begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      step_q        <= '0;
      stop_pend_q   <= 1'b0;
      wave_sel_s_q  <= '0;
      div_val_s_q   <= '0;
      amp_shift_s_q <= '0;
      osc_clr_q     <= 1'b0;
      wave_out_q    <= '0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      stop_pend_q   <= stop_pend_d;
      wave_sel_s_q  <= wave_sel_s_d;
      div_val_s_q   <= div_val_s_d;
      amp_shift_s_q <= amp_shift_s_d;
      osc_clr_q     <= osc_clr_d;
      wave_out_q    <= wave_out_d;
    end
  end

endmodule
